// File: rtl/vga_timing.sv
// 640x480@60 Hz raster generator: pixel/line counters, sync decode and a
// single output register stage that keeps blanked color aligned with sync.
module vga_timing #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        video_on,
    output logic        frame_tick,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS   = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS   = 12'(V_VISIBLE);
    localparam logic [11:0] HS_BEG  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END  = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        h_last, v_last;
    logic        hs_act, vs_act;

    always_comb begin
        h_last  = (h_cnt_q == H_LAST);
        v_last  = (v_cnt_q == V_LAST);
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            h_cnt_d = 12'd0;
            v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
        end

        video_on   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        frame_tick = h_last && v_last;

        // vertical sync is decoded from the line count only, so it covers hblank
        hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

        hs_d  = hs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_d  = vs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        rgb_d = video_on ? color : 3'b000;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            hs_q    <= ~SYNC_ACTIVE;
            vs_q    <= ~SYNC_ACTIVE;
            rgb_q   <= 3'b000;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            rgb_q   <= rgb_d;
        end
    end

    assign x      = h_cnt_q;
    assign y      = v_cnt_q;
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;
    assign VGA_R  = rgb_q[2];
    assign VGA_G  = rgb_q[1];
    assign VGA_B  = rgb_q[0];

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full horizontal timing, shortened vertical
// frame (24 lines) to keep frame-level checks short.
module tb_vga_timing;

    logic        CLOCK_25;
    logic        RESET_N;
    logic [2:0]  color;
    logic [11:0] x;
    logic [11:0] y;
    logic        video_on;
    logic        frame_tick;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_R;
    logic        VGA_G;
    logic        VGA_B;

    logic [2:0]  color_r;
    logic        gen_en;
    int          edge_n;
    int          n_checks;
    int          n_fail;

    vga_timing #(
        .V_VISIBLE(16),
        .V_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (4)
    ) dut (
        .CLOCK_25  (CLOCK_25),
        .RESET_N   (RESET_N),
        .color     (color),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .frame_tick(frame_tick),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B)
    );

    initial CLOCK_25 = 1'b0;
    always #20 CLOCK_25 = ~CLOCK_25;

    // stand-in for img_generator: red box in a small window, cyan elsewhere
    always_comb begin
        color = color_r;
        if (gen_en) begin
            color = 3'b011;
            if (y >= 12'd10 && y <= 12'd14 && x >= 12'd615 && x <= 12'd627)
                color = 3'b100;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
        edge_n++;
    endtask

    function automatic logic [2:0] rgb();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic rst_at(input string tag, input int xs, input int ys,
                          input logic [4:0] pre);
        bit found;
        found = 0;
        for (int i = 0; i < 25000; i++) begin
            if (x == 12'(xs) && y == 12'(ys)) begin
                found = 1;
                break;
            end
            tick();
        end
        check({tag, "_reach"}, found, 1);
        if (found) begin
            check({tag, "_pre"}, {VGA_HS, VGA_VS, rgb()}, pre);
            #5 RESET_N = 1'b0;
            #1;
            check({tag, "_x"}, x, 0);
            check({tag, "_y"}, y, 0);
            check({tag, "_pins"}, {VGA_HS, VGA_VS, rgb()}, 5'b11000);
            @(negedge CLOCK_25);
            RESET_N = 1'b1;
            edge_n  = 0;
            tick();
            check({tag, "_resume"}, {x, y}, {12'd1, 12'd0});
        end
    endtask

    initial begin
        int hs_fall0, hs_fall1, hs_rise0, hs_low0;
        int vs_fall, vs_rise, vs_low;
        int ft0, ft1, ft_cnt;
        int reg_cnt, reg_bad;
        int px, py;
        logic prev_hs, prev_vs;
        bit after_ft;

        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;
        gen_en   = 1'b0;
        color_r  = 3'b111;
        RESET_N  = 1'b0;

        #50;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_video_on", video_on, 1);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_pins", {VGA_HS, VGA_VS, rgb()}, 5'b11000);

        @(negedge CLOCK_25);
        RESET_N = 1'b1;

        hs_fall0 = 0; hs_fall1 = 0; hs_rise0 = 0; hs_low0 = 0;
        prev_hs  = 1'b1;
        for (int e = 1; e <= 1600; e++) begin
            tick();
            if (e == 1) begin
                check("e1_x", x, 1);
                check("e1_rgb", rgb(), 3'b111);
            end
            if (e == 640) begin
                check("e640_rgb", rgb(), 3'b111);
                check("e640_video_on", video_on, 0);
            end
            if (e == 641) check("e641_rgb", rgb(), 3'b000);
            if (e == 800) begin
                check("e800_rgb", rgb(), 3'b000);
                check("e800_xy", {x, y}, {12'd0, 12'd1});
            end
            if (e == 801) check("e801_rgb", rgb(), 3'b111);
            if (!VGA_HS && prev_hs) begin
                if (hs_fall0 == 0) hs_fall0 = edge_n;
                else if (hs_fall1 == 0) hs_fall1 = edge_n;
            end
            if (VGA_HS && !prev_hs && hs_rise0 == 0) hs_rise0 = edge_n;
            if (!VGA_HS && edge_n <= 800) hs_low0++;
            prev_hs = VGA_HS;
        end
        check("hs_first_low", hs_fall0, 657);
        check("hs_first_high", hs_rise0, 753);
        check("hs_low_width", hs_low0, 96);
        check("hs_period", hs_fall1 - hs_fall0, 800);

        vs_fall = 0; vs_rise = 0; vs_low = 0;
        ft0 = 0; ft1 = 0; ft_cnt = 0;
        prev_vs  = 1'b1;
        after_ft = 0;
        while (edge_n < 38400) begin
            tick();
            if (after_ft) begin
                check("wrap_xy", {x, y}, 24'd0);
                after_ft = 0;
            end
            if (!VGA_VS) vs_low++;
            if (!VGA_VS && prev_vs && vs_fall == 0) vs_fall = edge_n;
            if (VGA_VS && !prev_vs && vs_rise == 0) vs_rise = edge_n;
            prev_vs = VGA_VS;
            if (frame_tick) begin
                ft_cnt++;
                if (ft0 == 0) begin
                    ft0 = edge_n;
                    check("ft_xy", {x, y}, {12'd799, 12'd23});
                    after_ft = 1;
                end else if (ft1 == 0) begin
                    ft1 = edge_n;
                end
            end
        end
        check("vs_first_low", vs_fall, 14401);
        check("vs_first_high", vs_rise, 16001);
        check("vs_low_clocks", vs_low, 3200);
        check("ft_first", ft0, 19199);
        check("ft_period", ft1 - ft0, 19200);
        check("ft_count", ft_cnt, 2);

        gen_en  = 1'b1;
        reg_cnt = 0;
        reg_bad = 0;
        for (int i = 0; i < 20000; i++) begin
            px = int'(x);
            py = int'(y);
            if (py == 15) break;
            tick();
            if (py >= 10 && py <= 14 && px >= 615 && px <= 627) begin
                reg_cnt++;
                if (rgb() != 3'b100) reg_bad++;
            end
            if (px == 615 && py == 10) check("box_first", rgb(), 3'b100);
            if (px == 627 && py == 14) check("box_last", rgb(), 3'b100);
            if (px == 620 && py == 9)  check("box_above", rgb(), 3'b011);
            if (px == 614 && py == 12) check("box_left", rgb(), 3'b011);
            if (px == 628 && py == 12) check("box_right", rgb(), 3'b011);
            if (px == 640 && py == 12) check("box_blank", rgb(), 3'b000);
        end
        check("box_pixels", reg_cnt, 65);
        check("box_bad", reg_bad, 0);

        gen_en  = 1'b0;
        color_r = 3'b111;
        rst_at("rst_sync", 700, 19, 5'b00000);
        rst_at("rst_vis", 300, 5, 5'b11111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
